// File: rtl/ldt_tx_pkg.sv
// Shared types and constants for the LDT transmit sequencer.
package ldt_tx_pkg;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_GUARD,
      ST_TRAIN,
      ST_IDLE,
      ST_SHIFT
   } state_e;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Bits needed to count down from the largest of the three spans.
   function automatic int unsigned cnt_width(input int unsigned guard_cyc,
                                             input int unsigned train_cyc,
                                             input int unsigned frame_cyc);
      int unsigned m;
      m = guard_cyc;
      if (train_cyc > m) m = train_cyc;
      if (frame_cyc > m) m = frame_cyc;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/ldt_tx_shifter.sv
// Frame shifter: holds the remaining bits of the current frame and its bit index.
module ldt_tx_shifter
   import ldt_tx_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] data,
   output logic              tx_bit,
   output logic              last
);

   localparam int unsigned IDX_W = cnt_width(DATA_W + 2, 1, 1);

   logic [DATA_W:0]  sreg;
   logic [IDX_W-1:0] idx;

   // sreg[0] is always the bit to drive after the current one; the start bit is supplied by the caller.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= '0;
         idx  <= '0;
         last <= 1'b0;
      end else if (load) begin
         sreg <= {STOP_BIT, data};
         idx  <= '0;
         last <= 1'b0;
      end else if (shift) begin
         sreg <= {STOP_BIT, sreg[DATA_W:1]};
         idx  <= idx + IDX_W'(1);
         last <= (idx == IDX_W'(DATA_W));
      end
   end

   assign tx_bit = sreg[0];

endmodule

// File: rtl/ldt_tx_seq.sv
// LDT transmit sequencer: pad power-up (off/guard/train) then start/data/stop framing.
module ldt_tx_seq
   import ldt_tx_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned GUARD_CYC = 4,
   parameter int unsigned TRAIN_CYC = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic [DATA_W-1:0] TX_DATA,
   input  logic              TX_VALID,
   output logic              TX_READY,
   output logic              DOUT,
   output logic              DOUT_T,
   output logic              LINK_UP,
   output logic              BUSY
);

   localparam int unsigned CNT_W = cnt_width(GUARD_CYC, TRAIN_CYC, DATA_W + 2);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             en_lost, en_lost_nxt;
   logic             load, shift;
   logic             sh_bit, sh_last;
   logic             xfer;
   logic             dout_nxt, ready_nxt;

   assign xfer = TX_VALID & TX_READY;

   ldt_tx_shifter #(.DATA_W(DATA_W)) u_shifter (
      .clk    (CLK),
      .rst    (RST),
      .load   (load),
      .shift  (shift),
      .data   (TX_DATA),
      .tx_bit (sh_bit),
      .last   (sh_last)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_OFF;
         cnt      <= '0;
         en_lost  <= 1'b0;
         DOUT     <= IDLE_LEVEL;
         DOUT_T   <= 1'b1;
         TX_READY <= 1'b0;
         LINK_UP  <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         en_lost  <= en_lost_nxt;
         DOUT     <= dout_nxt;
         DOUT_T   <= (state_nxt == ST_OFF);
         TX_READY <= ready_nxt;
         LINK_UP  <= (state_nxt == ST_IDLE) || (state_nxt == ST_SHIFT);
         BUSY     <= (state_nxt == ST_GUARD) || (state_nxt == ST_TRAIN) ||
                     (state_nxt == ST_SHIFT);
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      en_lost_nxt = en_lost;
      load        = 1'b0;
      shift       = 1'b0;
      dout_nxt    = IDLE_LEVEL;
      ready_nxt   = 1'b0;

      case (state)
         ST_OFF: begin
            if (EN) begin
               state_nxt = ST_GUARD;
               cnt_nxt   = CNT_W'(GUARD_CYC - 1);
            end
         end
         ST_GUARD: begin
            if (!EN) begin
               state_nxt = ST_OFF;
            end else if (cnt == '0) begin
               state_nxt = ST_TRAIN;
               cnt_nxt   = CNT_W'(TRAIN_CYC - 1);
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_TRAIN: begin
            if (!EN) begin
               state_nxt = ST_OFF;
            end else if (cnt == '0) begin
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         ST_IDLE: begin
            if (xfer) begin
               state_nxt   = ST_SHIFT;
               load        = 1'b1;
               cnt_nxt     = CNT_W'(DATA_W + 1);
               en_lost_nxt = ~EN;
            end else if (!EN) begin
               state_nxt = ST_OFF;
            end
         end
         ST_SHIFT: begin
            // A dropped EN is remembered so the frame finishes and then powers down.
            if (!sh_last) begin
               shift       = 1'b1;
               cnt_nxt     = cnt - CNT_W'(1);
               en_lost_nxt = en_lost | ~EN;
            end else if (xfer) begin
               load        = 1'b1;
               cnt_nxt     = CNT_W'(DATA_W + 1);
               en_lost_nxt = ~EN;
            end else if (EN && !en_lost) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_OFF;
            end
         end
         default: begin
            state_nxt = ST_OFF;
         end
      endcase

      case (state_nxt)
         ST_TRAIN: dout_nxt = (state == ST_TRAIN) ? ~DOUT : 1'b0;
         ST_SHIFT: dout_nxt = load ? START_BIT : sh_bit;
         default:  dout_nxt = IDLE_LEVEL;
      endcase

      // Ready in IDLE, and in the stop cycle (counter 1 means the next bit is the stop bit).
      ready_nxt = (state_nxt == ST_IDLE) ||
                  (shift && (cnt == CNT_W'(1)) && EN && !en_lost);
   end

endmodule
